// File: rtl/mem_lsu_initiator_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_lsu_initiator_pkg : shared types and constants for the LSU initiator
// Revision: 1.0
// ----------------------------------------------------------------------------
package mem_lsu_initiator_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'd0,
    LSU_HALF = 2'd1,
    LSU_WORD = 2'd2
  } lsu_width_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_DATA = 2'd1,
    ST_RESP      = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int MEM_WORD_ADDR_BITS = 14;

  // Access width lives in the low two funct3 bits for both loads and stores.
  function automatic lsu_width_e width_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return LSU_BYTE;
      2'b01:   return LSU_HALF;
      default: return LSU_WORD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_initiator_load_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_load_align : selects and extends load data from a raw memory word
// Revision: 1.0
// ----------------------------------------------------------------------------
module lsu_load_align
  import mem_lsu_initiator_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (off_i)
      2'd0:    w_byte = word_i[7:0];
      2'd1:    w_byte = word_i[15:8];
      2'd2:    w_byte = word_i[23:16];
      default: w_byte = word_i[31:24];
    endcase
  end

  // Halfwords are 2-byte aligned, so only off_i[1] selects the half.
  assign w_half = off_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o = 32'h0;
    case (funct3_i)
      F3_LB:   data_o = {{24{w_byte[7]}}, w_byte};
      F3_LH:   data_o = {{16{w_half[15]}}, w_half};
      F3_LW:   data_o = word_i;
      F3_LBU:  data_o = {24'h0, w_byte};
      F3_LHU:  data_o = {16'h0, w_half};
      default: data_o = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu_initiator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_lsu_initiator : core load/store to byte-masked SPRAM initiator
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_lsu_initiator
  import mem_lsu_initiator_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_error,
  output logic [3:0]           mem_maskByte,
  output logic                 mem_write,
  output logic [ADDR_BITS-3:0] mem_address,
  output logic [31:0]          mem_dataWrite,
  input  logic [31:0]          mem_dataRead
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [31:0] w_rel;
  logic [1:0]  w_off;
  lsu_width_e  w_width;
  logic        w_in_window;
  logic        w_f3_legal;
  logic        w_aligned;
  logic        w_legal;
  logic        w_issue;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_rel       = req_addr - BASE_ADDR;
  assign w_off       = req_addr[1:0];
  assign w_width     = width_of(req_funct3);
  assign w_in_window = (w_rel >> ADDR_BITS) == 32'h0;

  always_comb begin
    w_f3_legal = 1'b0;
    case (req_funct3)
      F3_LB, F3_LH, F3_LW: w_f3_legal = 1'b1;
      F3_LBU, F3_LHU:      w_f3_legal = !req_write;
      default:             w_f3_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_aligned = 1'b1;
    w_mask    = 4'hF;
    w_wdata   = req_wdata;
    case (w_width)
      LSU_BYTE: begin
        w_mask  = 4'b0001 << w_off;
        w_wdata = {4{req_wdata[7:0]}};
      end
      LSU_HALF: begin
        w_aligned = !w_off[0];
        w_mask    = 4'b0011 << w_off;
        w_wdata   = {2{req_wdata[15:0]}};
      end
      default: begin
        w_aligned = (w_off == 2'b00);
      end
    endcase
  end

  assign w_legal = w_f3_legal && w_aligned && w_in_window;
  assign w_issue = (state_q == ST_IDLE) && req_valid && w_legal;

  lsu_load_align u_align (
    .word_i   (mem_dataRead),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_o   (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      rdata_q  <= 32'h0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    case (state_q)
      ST_IDLE: begin
        // req_ready is high throughout IDLE, so req_valid alone is the accept.
        if (req_valid) begin
          funct3_d = req_funct3;
          off_d    = w_off;
          rdata_d  = 32'h0;
          error_d  = !w_legal;
          state_d  = (w_legal && !req_write) ? ST_LOAD_DATA : ST_RESP;
        end
      end
      ST_LOAD_DATA: begin
        rdata_d = w_load_data;
        error_d = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          rdata_d = 32'h0;
          error_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == ST_IDLE);
    resp_valid    = (state_q == ST_RESP);
    resp_rdata    = rdata_q;
    resp_error    = error_q;
    mem_maskByte  = 4'h0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_dataWrite = 32'h0;
    if (w_issue) begin
      mem_maskByte  = w_mask;
      mem_write     = req_write;
      mem_address   = w_rel[ADDR_BITS-1:2];
      mem_dataWrite = w_wdata;
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_lsu_initiator.md
Name: mem_lsu_initiator

Overview:
- Load/store initiator that sits between the RV32 core datapath and the byte-masked SPRAM data memory (two 16-bit SPRAM halves, 14-bit word address, 4-bit byte mask).
- Converts a core load/store request (funct3, byte address, store data) into mask/address/lane-positioned write data.
- Waits out the SPRAM one-cycle read latency, then extracts and sign/zero-extends load data and returns it over a valid/ready response handshake.
- Rejects misaligned or out-of-window accesses without touching memory.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the memory window.
- ADDR_BITS, 16, byte-address bits covered by the window (64 KiB); word address width is ADDR_BITS-2 = 14.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response valid; held until resp_ready
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned, out-of-window or illegal funct3
- mem_maskByte  out  4  byte-lane enables to memory
- mem_write  out  1  memory write enable
- mem_address  out  14  memory word address = (req_addr-BASE_ADDR)[15:2]
- mem_dataWrite  out  32  lane-positioned store data
- mem_dataRead  in  32  raw 32-bit memory word, valid the cycle after a read strobe

Behaviour:
- Reset (async, rst_n low): state=IDLE; resp_valid=0, resp_error=0, resp_rdata=0. Combinational mem outputs are 0 in IDLE with no request.
- States: IDLE, LOAD_DATA, RESP.
- IDLE:
  - req_ready=1.
  - mem_* are driven combinationally from req_* only when req_valid=1 and the request is legal; otherwise mem_maskByte=0 and mem_write=0.
- Legality:
  - funct3 must be in the listed set (stores: 000/001/010 only).
  - Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - (addr-BASE_ADDR) must be < 2**ADDR_BITS.
- Mask generation (off = addr[1:0]):
  - byte: 4'b0001<<off
  - half: 4'b0011<<off
  - word: 4'b1111
- Store data: mem_dataWrite = replicate lane (byte x4, half x2, word) so the correct bytes land under the mask.
- Transitions out of IDLE on the accept edge (req_valid & req_ready):
  - Legal store: memory writes on that edge; go RESP with rdata=0, error=0. Latency: accept -> resp_valid 1 cycle.
  - Legal load: read issued on that edge; go LOAD_DATA.
  - Illegal: no memory strobe; go RESP with error=1, rdata=0.
- Registered request fields: funct3 and addr[1:0] are captured at accept.
- LOAD_DATA:
  - mem_maskByte=0 and mem_write=0.
  - Shift mem_dataRead right by off*8, truncate to byte/half, sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes through.
  - Register the result and go RESP. Load latency: accept -> resp_valid 2 cycles.
- RESP:
  - resp_valid=1 with resp_rdata/resp_error stable.
  - On resp_ready: go IDLE. No new request is accepted in the same cycle; back-to-back throughput is one request per 2 (store) or 3 (load) cycles.
- Reset mid-operation: any in-flight load is dropped; no response is produced.
- Stores never assert resp_error except when illegal.

Decomposition:
- Package MemoryBus gets:
  - LsuWidth enum (BYTE, HALF, WORD)
  - funct3 constants
  - LsuState enum
  - MEM_WORD_ADDR_BITS = 14
- Sub-module lsu_load_align: combinational mem word + offset + funct3 -> extended 32-bit result. Shared with the test bench's reference model.

Test Plan:
- SW addr 0x0000_0010, wdata 0xDEADBEEF -> mask 1111, address 4, dataWrite 0xDEADBEEF, write=1; resp_valid next cycle, error=0.
- SB addr 0x13, wdata 0x000000A5 -> mask 1000, address 4, dataWrite 0xA5A5A5A5; followed by LW 0x10 with memory returning 0xA5ADBEEF -> resp_rdata 0xA5ADBEEF at cycle accept+2.
- LB addr 0x13 with memory word 0x80000000 -> 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x12 with memory word 0x8001xxxx -> 0xFFFF8001; LHU same -> 0x00008001.
- LW addr 0x2, SH addr 0x1, and LW addr 0x0001_0000 (BASE 0) -> mem_maskByte=0 and mem_write=0 throughout; resp_error=1 and rdata=0 after 1 cycle.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0; release -> IDLE next cycle.
- Assert rst_n=0 during LOAD_DATA -> resp_valid=0 immediately, state IDLE; next request behaves normally.
